// File: rtl/ch0re_ifetch_pkg.sv
// Shared types and constants for the ch0re instruction fetch stage.
package ch0re_ifetch_pkg;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

  // Canonical RISC-V NOP (addi x0, x0, 0); handy filler for benches.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // One buffered fetch result as presented to decode.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        misaligned;
  } fetch_entry_t;

  // Classification of a memory response in the current cycle.
  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_DROP,
    RESP_KEEP
  } resp_kind_t;

  function automatic logic is_misaligned(input logic [63:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ch0re_ifetch_fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush overrides push and pop.
module ch0re_fetch_fifo
  import ch0re_ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  fetch_entry_t             i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output fetch_entry_t             o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign o_empty = (count == '0);
  assign o_full  = (count == (PW+1)'(DEPTH));
  assign o_count = count;
  assign pop_ok  = i_pop && !o_empty && !i_flush;
  assign push_ok = i_push && !i_flush && (!o_full || pop_ok);

  // Head is forced to zero while empty so idle outputs are clean.
  assign o_head = o_empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    end
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/ch0re_ifetch.sv
// Instruction fetch: PC generation, in-order memory requests, response
// buffering and redirect flushing, feeding decode over valid/ready.
module ch0re_ifetch
  import ch0re_ifetch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [63:0] RESET_PC   = DEFAULT_RESET_PC
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [63:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [63:0] i_redirect_pc,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [63:0] o_pc,
  output logic        o_misaligned,
  input  logic        i_instr_ready
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [63:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic          mis_done;
  logic [63:0]   req_pc_q [FIFO_DEPTH];
  logic [PW-1:0] req_wr;
  logic [PW-1:0] req_rd;

  logic          misaligned_pc;
  logic [CW:0]   inflight;
  logic          credit_ok;
  logic          imem_req;
  logic          issue;
  logic          resp;
  resp_kind_t    resp_kind;
  logic          mis_push;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  assign misaligned_pc = is_misaligned(pc);
  assign inflight      = {1'b0, outstanding} + {1'b0, fifo_count};
  assign credit_ok     = inflight < (CW+1)'(FIFO_DEPTH);
  assign imem_req      = i_rst_n && !i_redirect && !misaligned_pc && credit_ok;
  assign issue         = imem_req && i_imem_gnt;
  // Responses with nothing outstanding belong to pre-reset requests.
  assign resp          = i_imem_rvalid && (outstanding != '0);

  assign mis_push = !i_redirect && misaligned_pc && !mis_done &&
                    (outstanding == '0) && (discard == '0) && fifo_empty;
  assign fifo_push = (resp_kind == RESP_KEEP) || mis_push;
  assign fifo_pop  = !fifo_empty && i_instr_ready;

  // Decide whether this cycle's response is kept or dropped.
  always_comb begin
    resp_kind = RESP_NONE;
    if (resp) begin
      resp_kind = (i_redirect || (discard != '0)) ? RESP_DROP : RESP_KEEP;
    end
  end

  // Build the entry to push: memory word with its request PC, or the
  // zero-word marker for a misaligned target.
  always_comb begin
    push_entry.pc         = req_pc_q[req_rd];
    push_entry.instr      = i_imem_rdata;
    push_entry.misaligned = 1'b0;
    if (mis_push) begin
      push_entry.pc         = pc;
      push_entry.instr      = '0;
      push_entry.misaligned = 1'b1;
    end
  end

  // PC, outstanding/discard counters and request-PC queue pointers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      mis_done    <= 1'b0;
      req_wr      <= '0;
      req_rd      <= '0;
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(resp);
      if (issue) req_wr <= req_wr + PW'(1);
      if (resp)  req_rd <= req_rd + PW'(1);
      if (i_redirect) begin
        pc       <= i_redirect_pc;
        // Every request still in flight is stale after a redirect, and
        // outstanding already includes those awaiting discard, so the
        // discard count restarts from outstanding instead of summing.
        discard  <= outstanding - CW'(resp);
        mis_done <= 1'b0;
      end else begin
        if (issue) pc <= pc + 64'd4;
        if (resp_kind == RESP_DROP) discard <= discard - CW'(1);
        if (mis_push) mis_done <= 1'b1;
      end
    end
  end

  // Remember the PC of each issued request for its in-order response.
  always_ff @(posedge i_clk) begin
    if (issue) req_pc_q[req_wr] <= pc;
  end

  // A kept response must always find room in the buffer.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      assert (!((resp_kind == RESP_KEEP) && fifo_full && !fifo_pop))
        else $fatal(1, "ch0re_ifetch: response would overflow instruction buffer");
    end
  end

  ch0re_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (fifo_push),
    .i_push_data (push_entry),
    .i_pop       (fifo_pop),
    .i_flush     (i_redirect),
    .o_head      (head),
    .o_count     (fifo_count),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty)
  );

  assign o_imem_req    = imem_req;
  assign o_imem_addr   = pc;
  assign o_instr_valid = !fifo_empty;
  assign o_instr       = head.instr;
  assign o_pc          = head.pc;
  assign o_misaligned  = head.misaligned;

endmodule

// File: tb/tb_ch0re_ifetch.sv
// Bench for ch0re_ifetch: in-order memory responder plus a queue-based
// reference of the fetch stage, with directed and random scenarios.
module tb_ch0re_ifetch;
  import ch0re_ifetch_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [63:0] RPC   = 64'h1000;

  logic        clk;
  logic        i_rst_n;
  logic        o_imem_req;
  logic [63:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        i_redirect;
  logic [63:0] i_redirect_pc;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [63:0] o_pc;
  logic        o_misaligned;
  logic        i_instr_ready;

  ch0re_ifetch #(
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (RPC)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (i_rst_n),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_instr_valid (o_instr_valid),
    .o_instr       (o_instr),
    .o_pc          (o_pc),
    .o_misaligned  (o_misaligned),
    .i_instr_ready (i_instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    bit          mis;
  } exp_t;

  typedef struct {
    logic [63:0] pc;
    bit          stale;
  } req_t;

  // Reference: requests in flight and instructions visible to decode.
  exp_t        expq[$];
  req_t        outq[$];
  logic [63:0] mpc;
  bit          m_hold;

  // Memory responder state.
  logic [63:0] mem_addr_q[$];
  int          mem_cyc_q[$];
  int          cyc;

  int gnt_pct, rv_pct, rdy_pct;
  int n_checks, n_fail;

  bit          obs_req, obs_valid, obs_mis, obs_rv, obs_fire, obs_issue, obs_rdy;
  logic [63:0] obs_addr, obs_pc;
  logic [31:0] obs_instr;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {a[17:2], ~a[17:2]} ^ 32'h5a5a_1234 ^ a[49:18];
  endfunction

  task automatic model_reset();
    mpc = RPC;
    expq.delete();
    outq.delete();
    m_hold = 0;
    mem_addr_q.delete();
    mem_cyc_q.delete();
  endtask

  // One clock of stimulus, checking and reference update.
  task automatic step(input bit redir, input logic [63:0] tgt);
    bit   exp_req, issue, mis_ok;
    req_t r;
    @(negedge clk);
    i_redirect    = redir;
    i_redirect_pc = tgt;
    i_imem_gnt    = ($urandom_range(99) < gnt_pct);
    i_instr_ready = ($urandom_range(99) < rdy_pct);
    if (mem_addr_q.size() > 0 && mem_cyc_q[0] < cyc && $urandom_range(99) < rv_pct) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = mem_word(mem_addr_q[0]);
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = ($urandom_range(1) == 0) ? NOP_INSTR : $urandom;
    end
    #1;
    exp_req = !redir && (mpc[1:0] == 2'b00) && (outq.size() + expq.size() < DEPTH);
    n_checks++;
    if (o_imem_req !== exp_req) begin
      n_fail++;
      $display("FAIL imem_req cyc=%0d: got %b expected %b", cyc, o_imem_req, exp_req);
    end
    if (exp_req) begin
      n_checks++;
      if (o_imem_addr !== mpc) begin
        n_fail++;
        $display("FAIL imem_addr cyc=%0d: got %h expected %h", cyc, o_imem_addr, mpc);
      end
    end
    n_checks++;
    if (o_instr_valid !== (expq.size() != 0)) begin
      n_fail++;
      $display("FAIL instr_valid cyc=%0d: got %b expected %b", cyc, o_instr_valid, expq.size() != 0);
    end
    if (expq.size() != 0) begin
      n_checks++;
      if (o_pc !== expq[0].pc || o_instr !== expq[0].instr || o_misaligned !== expq[0].mis) begin
        n_fail++;
        $display("FAIL head cyc=%0d: got pc=%h instr=%h mis=%b expected pc=%h instr=%h mis=%b",
                 cyc, o_pc, o_instr, o_misaligned, expq[0].pc, expq[0].instr, expq[0].mis);
      end
    end
    obs_req   = o_imem_req;
    obs_addr  = o_imem_addr;
    obs_valid = o_instr_valid;
    obs_pc    = o_pc;
    obs_instr = o_instr;
    obs_mis   = o_misaligned;
    obs_rv    = i_imem_rvalid;
    obs_rdy   = i_instr_ready;
    obs_issue = o_imem_req && i_imem_gnt;
    obs_fire  = o_instr_valid && i_instr_ready && !redir;
    @(posedge clk);
    if (i_imem_rvalid) begin
      void'(mem_addr_q.pop_front());
      void'(mem_cyc_q.pop_front());
    end
    if (obs_issue) begin
      mem_addr_q.push_back(obs_addr);
      mem_cyc_q.push_back(cyc);
    end
    issue = exp_req && i_imem_gnt;
    if (redir) begin
      expq.delete();
      foreach (outq[k]) outq[k].stale = 1;
      if (i_imem_rvalid && outq.size() > 0) void'(outq.pop_front());
      mpc    = tgt;
      m_hold = 0;
    end else begin
      mis_ok = (mpc[1:0] != 2'b00) && !m_hold && outq.size() == 0 && expq.size() == 0;
      if (expq.size() != 0 && i_instr_ready) void'(expq.pop_front());
      if (i_imem_rvalid && outq.size() > 0) begin
        r = outq.pop_front();
        if (!r.stale) expq.push_back('{r.pc, mem_word(r.pc), 1'b0});
      end
      if (issue) begin
        outq.push_back('{mpc, 1'b0});
        mpc = mpc + 64'd4;
      end
      if (mis_ok) begin
        expq.push_back('{mpc, 32'h0, 1'b1});
        m_hold = 1;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst_n       = 1'b0;
    i_redirect    = 1'b0;
    i_imem_gnt    = 1'b0;
    i_imem_rvalid = 1'b0;
    i_instr_ready = 1'b0;
    #1;
    n_checks++;
    if (o_imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL req_in_reset: got %b expected 0", o_imem_req);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (o_imem_req !== 1'b0 || o_instr_valid !== 1'b0 || o_instr !== 32'h0 ||
        o_pc !== 64'h0 || o_misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b valid=%b instr=%h pc=%h mis=%b expected all zero",
               o_imem_req, o_instr_valid, o_instr, o_pc, o_misaligned);
    end
    @(posedge clk);
    #1 i_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic set_pct(input int g, input int r, input int d);
    gnt_pct = g;
    rv_pct  = r;
    rdy_pct = d;
  endtask

  task automatic test_reset();
    do_reset();
    set_pct(100, 100, 100);
    step(0, '0);
    n_checks++;
    if (obs_req !== 1'b1 || obs_addr !== RPC) begin
      n_fail++;
      $display("FAIL first_fetch: got req=%b addr=%h expected req=1 addr=%h", obs_req, obs_addr, RPC);
    end
  endtask

  task automatic test_stream();
    logic [63:0] want;
    do_reset();
    set_pct(100, 100, 100);
    for (int k = 0; k < 10; k++) begin
      step(0, '0);
      if (k >= 2) begin
        want = RPC + 64'(4 * (k - 2));
        n_checks++;
        if (obs_valid !== 1'b1 || obs_pc !== want || obs_instr !== mem_word(want)) begin
          n_fail++;
          $display("FAIL stream k=%0d: got valid=%b pc=%h instr=%h expected pc=%h instr=%h",
                   k, obs_valid, obs_pc, obs_instr, want, mem_word(want));
        end
      end
    end
  endtask

  task automatic test_stall();
    int          issues;
    int          pops;
    logic [63:0] first_pc;
    set_pct(100, 100, 0);
    issues = 0;
    for (int k = 0; k < 5; k++) begin
      step(0, '0);
      if (k == 0) first_pc = obs_pc;
      if (obs_issue) issues++;
    end
    n_checks++;
    if (issues > DEPTH || obs_req !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_credit: got issues=%0d last_req=%b expected issues<=%0d last_req=0",
               issues, obs_req, DEPTH);
    end
    rdy_pct = 100;
    pops = 0;
    for (int k = 0; k < 10; k++) begin
      step(0, '0);
      if (obs_fire) begin
        n_checks++;
        if (obs_pc !== first_pc + 64'(4 * pops)) begin
          n_fail++;
          $display("FAIL stall_order: got pc=%h expected %h", obs_pc, first_pc + 64'(4 * pops));
        end
        pops++;
      end
    end
    n_checks++;
    if (pops < 8) begin
      n_fail++;
      $display("FAIL stall_drain: got %0d pops expected at least 8", pops);
    end
  endtask

  // Step until decode sees an instruction; check it is the target PC.
  task automatic expect_first(input string name, input logic [63:0] want);
    bit found;
    found = 0;
    for (int k = 0; k < 12 && !found; k++) begin
      step(0, '0);
      if (obs_valid) found = 1;
    end
    n_checks++;
    if (!found || obs_pc !== want) begin
      n_fail++;
      $display("FAIL %s: got found=%b pc=%h expected pc=%h", name, found, obs_pc, want);
    end
  endtask

  task automatic test_redirect_outstanding();
    do_reset();
    set_pct(100, 0, 100);
    step(0, '0);
    step(0, '0);
    step(1, 64'h2000);
    rv_pct = 100;
    expect_first("redirect_outstanding", 64'h2000);
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    set_pct(100, 100, 100);
    repeat (4) step(0, '0);
    step(1, 64'h4000);
    n_checks++;
    if (!(obs_rv && obs_valid && obs_rdy)) begin
      n_fail++;
      $display("FAIL same_cycle_setup: got rvalid=%b valid=%b ready=%b expected all 1",
               obs_rv, obs_valid, obs_rdy);
    end
    expect_first("redirect_same_cycle", 64'h4000);
  endtask

  task automatic test_misaligned();
    int reqs;
    int mis_pops;
    set_pct(100, 100, 100);
    repeat (3) step(0, '0);
    step(1, 64'h2002);
    reqs = 0;
    mis_pops = 0;
    for (int k = 0; k < 8; k++) begin
      step(0, '0);
      if (obs_req) reqs++;
      if (obs_fire) begin
        mis_pops++;
        n_checks++;
        if (obs_pc !== 64'h2002 || obs_instr !== 32'h0 || obs_mis !== 1'b1) begin
          n_fail++;
          $display("FAIL misaligned_entry: got pc=%h instr=%h mis=%b expected pc=2002 instr=0 mis=1",
                   obs_pc, obs_instr, obs_mis);
        end
      end
    end
    n_checks++;
    if (reqs != 0 || mis_pops != 1) begin
      n_fail++;
      $display("FAIL misaligned_hold: got reqs=%0d entries=%0d expected reqs=0 entries=1", reqs, mis_pops);
    end
    step(1, 64'h3000);
    step(0, '0);
    n_checks++;
    if (obs_req !== 1'b1 || obs_addr !== 64'h3000) begin
      n_fail++;
      $display("FAIL misaligned_resume: got req=%b addr=%h expected req=1 addr=3000", obs_req, obs_addr);
    end
  endtask

  task automatic test_gnt_stall();
    do_reset();
    set_pct(100, 100, 100);
    step(0, '0);
    step(0, '0);
    gnt_pct = 0;
    for (int k = 0; k < 3; k++) begin
      step(0, '0);
      n_checks++;
      if (obs_req !== 1'b1 || obs_addr !== RPC + 64'h8) begin
        n_fail++;
        $display("FAIL gnt_hold k=%0d: got req=%b addr=%h expected req=1 addr=%h",
                 k, obs_req, obs_addr, RPC + 64'h8);
      end
    end
    gnt_pct = 100;
    step(0, '0);
    step(0, '0);
    n_checks++;
    if (obs_addr !== RPC + 64'hc) begin
      n_fail++;
      $display("FAIL gnt_advance: got addr=%h expected %h", obs_addr, RPC + 64'hc);
    end
  endtask

  task automatic test_wrap();
    int          pops;
    logic [63:0] base;
    base = 64'hFFFF_FFFF_FFFF_FFF8;
    set_pct(100, 100, 100);
    step(1, base);
    pops = 0;
    for (int k = 0; k < 8; k++) begin
      step(0, '0);
      if (obs_fire) begin
        n_checks++;
        if (obs_pc !== base + 64'(4 * pops)) begin
          n_fail++;
          $display("FAIL wrap: got pc=%h expected %h", obs_pc, base + 64'(4 * pops));
        end
        pops++;
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] t;
    bit          rd;
    for (int k = 0; k < 1500; k++) begin
      if (k % 64 == 0) set_pct($urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(20, 100));
      if (k == 700) do_reset();
      rd = ($urandom_range(99) < 4);
      t = {$urandom, $urandom};
      if ($urandom_range(3) != 0) t[63:20] = '0;
      else if ($urandom_range(3) == 0) t[63:20] = '1;
      t[1:0] = ($urandom_range(5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step(rd, t);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    cyc           = 0;
    i_rst_n       = 1'b0;
    i_imem_gnt    = 1'b0;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = '0;
    i_redirect    = 1'b0;
    i_redirect_pc = '0;
    i_instr_ready = 1'b0;
    model_reset();
    set_pct(100, 100, 100);

    test_reset();
    test_stream();
    test_stall();
    test_redirect_outstanding();
    test_redirect_same_cycle();
    test_misaligned();
    test_gnt_stall();
    test_wrap();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
